user_mux_rd_sched: RTL and testbench
====================================

USER_MUX_RD_SCHED -- requirements
Module: user_mux_rd_sched

Interface
REQ-001 SHALL have parameter N_DESTS, default 4, number of demux destinations (1..2**DEST_BITS).
REQ-002 SHALL have parameter DEST_BITS, default 2, width of destination select.
REQ-003 SHALL have parameter QDEPTH, default 4, route-request queue depth (power of 2, >=2).
REQ-004 SHALL have port aclk  input  1  sole clock, all logic rising-edge.
REQ-005 SHALL have port areset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  route request valid.
REQ-007 SHALL have port req_ready  output  1  queue can accept request.
REQ-008 SHALL have port req_dest  input  DEST_BITS  destination index for request.
REQ-009 SHALL have port req_pkts  input  8  packet count to route to req_dest.
REQ-010 SHALL have port s_tvalid  input  1  upstream stream beat valid.
REQ-011 SHALL have port s_tlast  input  1  upstream beat is last of packet.
REQ-012 SHALL have port s_tready  output  1  ready returned to upstream.
REQ-013 SHALL have port mux_tvalid  output  1  gated valid into demux slave.
REQ-014 SHALL have port mux_tready  input  1  ready from demux slave.
REQ-015 SHALL have port port_sel  output  DEST_BITS  demux destination select.
REQ-016 SHALL have port busy  output  1  high while in ROUTE.
REQ-017 SHALL have port pkt_done  output  1  one-cycle pulse per completed packet.
REQ-018 SHALL have port err_drop  output  1  one-cycle pulse per discarded request.

Function
REQ-019 SHALL buffer requests {req_dest, req_pkts} in a QDEPTH-entry FIFO; push on req_valid && req_ready.
REQ-020 SHALL drive req_ready = !full, registered count only; no push while full even if a pop occurs that cycle.
REQ-021 SHALL not bypass: a request pushed into an empty queue becomes poppable the following cycle.
REQ-022 SHALL implement FSM states IDLE and ROUTE.
REQ-023 In IDLE with queue non-empty, SHALL pop the head entry in that cycle.
REQ-024 If popped req_dest >= N_DESTS or req_pkts == 0, SHALL pulse err_drop next cycle and remain IDLE.
REQ-025 Otherwise SHALL register port_sel = req_dest, remaining = req_pkts, and enter ROUTE next cycle.
REQ-026 In IDLE, s_tready and mux_tvalid SHALL be 0; port_sel SHALL hold its last value.
REQ-027 In ROUTE, mux_tvalid = s_tvalid and s_tready = mux_tready, combinationally (zero-latency pass-through).
REQ-028 Beat transfer SHALL be defined as s_tvalid && mux_tready while in ROUTE.
REQ-029 On transfer with s_tlast, SHALL pulse pkt_done next cycle and decrement remaining.
REQ-030 When remaining decrements from 1 to 0, SHALL return to IDLE next cycle; port_sel SHALL not change mid-packet.
REQ-031 From IDLE, first beat of a new grant SHALL be transferable no earlier than the cycle after the pop.
REQ-032 busy SHALL equal (state == ROUTE), registered.
REQ-033 Remaining counter SHALL be 8 bits, no wrap; req_pkts = 255 routes exactly 255 packets.

Reset
REQ-034 On areset, FIFO SHALL empty; state = IDLE; port_sel = 0; remaining = 0; busy, pkt_done, err_drop = 0.
REQ-035 During and one cycle after areset, req_ready, s_tready and mux_tvalid SHALL be 0.
REQ-036 Reset mid-packet SHALL abandon the packet with no pkt_done; the upstream source is reset alongside.

Verification
REQ-037 Push {dest=2, pkts=1}; send 3-beat packet, mux_tready=1 -> port_sel=2, 3 transfers, one pkt_done, return to IDLE, busy low.
REQ-038 Push {1,2}, then {3,1}; send 3 packets -> packets 1-2 on port_sel=1, packet 3 on port_sel=3, 3 pkt_done pulses.
REQ-039 Push {dest=5 with N_DESTS=4, pkts=1} and {0,0} -> two err_drop pulses, state stays IDLE, s_tready stays 0.
REQ-040 Push QDEPTH+1 requests without stream traffic -> req_ready low after QDEPTH pushes; extra request held until a pop.
REQ-041 In ROUTE, toggle mux_tready 1,0,1 with s_tvalid held -> s_tready mirrors it; beat count unchanged during stall.
REQ-042 Assert areset during beat 2 of a 4-beat packet -> no pkt_done, state IDLE, FIFO empty, port_sel=0 one cycle after.

Source files
------------

// File: rtl/user_mux_rd_sched_if.sv
// Handshake bundle between a route-request source / stream source and the
// read scheduler that gates a stream into a demux slave.
interface user_mux_rd_sched_if #(
    parameter int DEST_BITS = 2
);
    logic                 req_valid;
    logic                 req_ready;
    logic [DEST_BITS-1:0] req_dest;
    logic [7:0]           req_pkts;
    logic                 s_tvalid;
    logic                 s_tlast;
    logic                 s_tready;
    logic                 mux_tvalid;
    logic                 mux_tready;
    logic [DEST_BITS-1:0] port_sel;
    logic                 busy;
    logic                 pkt_done;
    logic                 err_drop;

    modport slave (
        input  req_valid, req_dest, req_pkts, s_tvalid, s_tlast, mux_tready,
        output req_ready, s_tready, mux_tvalid, port_sel, busy, pkt_done, err_drop
    );

    modport master (
        output req_valid, req_dest, req_pkts, s_tvalid, s_tlast, mux_tready,
        input  req_ready, s_tready, mux_tvalid, port_sel, busy, pkt_done, err_drop
    );
endinterface

// File: rtl/user_mux_rd_sched.sv
// Route-request scheduler: queues {dest, pkts} grants and passes the upstream
// stream to one demux destination until the granted packet count completes.
module user_mux_rd_sched #(
    parameter int N_DESTS   = 4,
    parameter int DEST_BITS = 2,
    parameter int QDEPTH    = 4
) (
    input logic                aclk,
    input logic                areset,
    user_mux_rd_sched_if.slave bus
);
    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [DEST_BITS-1:0] dest;
        logic [7:0]           pkts;
    } req_t;

    typedef enum logic {IDLE, ROUTE} state_t;

    req_t                 mem [QDEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    state_t               state_q, state_d;
    logic [DEST_BITS-1:0] port_sel_q, port_sel_d;
    logic [7:0]           remaining_q, remaining_d;
    logic                 busy_q, busy_d;
    logic                 pkt_done_q, pkt_done_d;
    logic                 err_drop_q, err_drop_d;
    logic                 live_q, live_d;

    logic push, pop, xfer, in_route, head_bad;
    req_t head;

    // Outputs are forced low while reset is asserted and, via live_q, for one cycle after.
    assign in_route       = (state_q == ROUTE) && !areset;
    assign bus.req_ready  = live_q && !areset && (count_q != CW'(QDEPTH));
    assign bus.mux_tvalid = in_route && bus.s_tvalid;
    assign bus.s_tready   = in_route && bus.mux_tready;
    assign xfer           = in_route && bus.s_tvalid && bus.mux_tready;
    assign push           = bus.req_valid && bus.req_ready;
    assign pop            = (state_q == IDLE) && (count_q != '0) && !areset;
    assign head           = mem[rd_ptr_q];
    assign head_bad       = (32'(head.dest) >= N_DESTS) || (head.pkts == 8'd0);

    assign bus.port_sel = port_sel_q;
    assign bus.busy     = busy_q;
    assign bus.pkt_done = pkt_done_q;
    assign bus.err_drop = err_drop_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        wr_ptr_d    = wr_ptr_q + AW'(push);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        count_d     = count_q + CW'(push) - CW'(pop);
        state_d     = state_q;
        port_sel_d  = port_sel_q;
        remaining_d = remaining_q;
        pkt_done_d  = 1'b0;
        err_drop_d  = 1'b0;
        live_d      = 1'b1;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    if (head_bad) begin
                        err_drop_d = 1'b1;
                    end else begin
                        state_d     = ROUTE;
                        port_sel_d  = head.dest;
                        remaining_d = head.pkts;
                    end
                end
            end
            ROUTE: begin
                // remaining_q is never zero in ROUTE, so the decrement cannot wrap.
                if (xfer && bus.s_tlast) begin
                    pkt_done_d  = 1'b1;
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == ROUTE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            port_sel_q  <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            pkt_done_q  <= 1'b0;
            err_drop_q  <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            port_sel_q  <= port_sel_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            pkt_done_q  <= pkt_done_d;
            err_drop_q  <= err_drop_d;
            live_q      <= live_d;
        end
    end

    // NOTE: queue storage has no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr_q] <= req_t'{dest: bus.req_dest, pkts: bus.req_pkts};
    end
endmodule

// File: tb/tb_user_mux_rd_sched.sv
// Scoreboard bench for user_mux_rd_sched: accepted requests expand into an
// ordered list of expected drop / packet events that a negedge monitor consumes.
module tb_user_mux_rd_sched;
    localparam int ND = 4;
    localparam int DB = 3;
    localparam int QD = 4;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    user_mux_rd_sched_if #(.DEST_BITS(DB)) bus ();

    user_mux_rd_sched #(.N_DESTS(ND), .DEST_BITS(DB), .QDEPTH(QD)) dut (
        .aclk  (aclk),
        .areset(areset),
        .bus   (bus)
    );

    typedef struct {
        bit drop;
        int dest;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0, n_err = 0;
    int  xfer_cnt = 0, done_cnt = 0, drop_cnt = 0;
    bit  s_fire = 1'b0;
    bit  stream_en, rand_ready, ready_force;
    int  valid_pct, fixed_len;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a request is one drop event if unroutable, else pkts packet events.
    function automatic void model_accept(input int d, input int p);
        ev_t ev;
        if (d >= ND || p == 0) begin
            ev.drop = 1'b1; ev.dest = d;
            exp_q.push_back(ev);
        end else begin
            for (int i = 0; i < p; i++) begin
                ev.drop = 1'b0; ev.dest = d;
                exp_q.push_back(ev);
            end
        end
    endfunction

    function automatic int pick_len();
        return (fixed_len != 0) ? fixed_len : int'($urandom_range(1, 4));
    endfunction

    always @(negedge aclk) begin
        ev_t ev;
        if (areset) begin
            exp_q.delete();
            s_fire = 1'b0;
        end else begin
            s_fire = bus.s_tvalid && bus.s_tready;
            if (bus.err_drop) begin
                check("err_drop_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    ev = exp_q.pop_front();
                    check("err_drop_kind", ev.drop, 1);
                end
                drop_cnt++;
            end
            if (bus.pkt_done) begin
                check("pkt_done_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    ev = exp_q.pop_front();
                    check("pkt_done_kind", ev.drop, 0);
                end
                done_cnt++;
            end
            if (bus.mux_tvalid && bus.mux_tready) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("beat_kind", exp_q[0].drop, 0);
                    check("beat_port_sel", 32'(bus.port_sel), exp_q[0].dest);
                end
                xfer_cnt++;
            end
            check("s_tready_gate", bus.s_tready, bus.busy ? bus.mux_tready : 1'b0);
            check("mux_tvalid_gate", bus.mux_tvalid, bus.busy ? bus.s_tvalid : 1'b0);
            if (bus.req_valid && bus.req_ready) model_accept(int'(bus.req_dest), int'(bus.req_pkts));
        end
    end

    // Upstream stream source and demux-side ready; reset alongside the DUT.
    initial begin : drv
        int beat = 0;
        int len  = 1;
        bus.s_tvalid   = 1'b0;
        bus.s_tlast    = 1'b0;
        bus.mux_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #2;
            if (areset) begin
                beat = 0;
                len  = pick_len();
                bus.s_tvalid = 1'b0;
            end else begin
                if (s_fire) begin
                    if (beat == len - 1) begin
                        beat = 0;
                        len  = pick_len();
                    end else begin
                        beat++;
                    end
                end
                if (!stream_en) bus.s_tvalid = 1'b0;
                else if (!(bus.s_tvalid && !s_fire))
                    bus.s_tvalid = ($urandom_range(1, 100) <= valid_pct);
            end
            bus.s_tlast    = (beat == len - 1);
            bus.mux_tready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    task automatic tb_reset();
        @(posedge aclk); #1 areset = 1'b1;
        @(posedge aclk); #1 areset = 1'b0;
        @(posedge aclk); #1;
    endtask

    task automatic push_req(input int d, input int p);
        int t = 0;
        bus.req_valid = 1'b1;
        bus.req_dest  = DB'(d);
        bus.req_pkts  = 8'(p);
        @(negedge aclk);
        while (!bus.req_ready && t < 3000) begin
            @(negedge aclk);
            t++;
        end
        check("push_accepted", bus.req_ready, 1);
        @(posedge aclk); #1 bus.req_valid = 1'b0;
    endtask

    task automatic drain(input int max);
        int t = 0;
        while ((exp_q.size() != 0 || bus.busy) && t < max) begin
            @(negedge aclk);
            t++;
        end
        check("drain_in_time", exp_q.size(), 0);
        repeat (2) @(negedge aclk);
        check("busy_after_drain", bus.busy, 0);
        @(posedge aclk); #1;
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c0, d0, r0, t;
        areset = 1'b1;
        bus.req_valid = 1'b0; bus.req_dest = '0; bus.req_pkts = '0;
        stream_en = 1'b1; valid_pct = 100; fixed_len = 3; rand_ready = 1'b0; ready_force = 1'b1;

        // Reset state, then req_ready held low for one more cycle after release.
        repeat (2) @(posedge aclk);
        repeat (2) begin
            @(negedge aclk);
            check("rst_req_ready", bus.req_ready, 0);
            check("rst_s_tready", bus.s_tready, 0);
            check("rst_mux_tvalid", bus.mux_tvalid, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_pkt_done", bus.pkt_done, 0);
            check("rst_err_drop", bus.err_drop, 0);
            check("rst_port_sel", bus.port_sel, 0);
        end
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        check("post_rst_req_ready", bus.req_ready, 0);
        check("post_rst_s_tready", bus.s_tready, 0);
        @(negedge aclk);
        check("req_ready_live", bus.req_ready, 1);
        @(posedge aclk); #1;

        // Single 3-beat packet to destination 2.
        c0 = xfer_cnt; d0 = done_cnt;
        push_req(2, 1);
        drain(200);
        check("t1_beats", xfer_cnt - c0, 3);
        check("t1_pkt_done", done_cnt - d0, 1);
        check("t1_port_sel_hold", bus.port_sel, 2);

        // Two grants back to back: {1,2} then {3,1}.
        fixed_len = 0; valid_pct = 60;
        tb_reset();
        d0 = done_cnt;
        push_req(1, 2);
        push_req(3, 1);
        drain(500);
        check("t2_pkt_done", done_cnt - d0, 3);
        check("t2_port_sel_last", bus.port_sel, 3);

        // Unroutable requests are dropped without opening the stream.
        tb_reset();
        r0 = drop_cnt;
        push_req(5, 1);
        push_req(0, 0);
        repeat (4) begin
            @(negedge aclk);
            check("t3_s_tready_low", bus.s_tready, 0);
            check("t3_busy_low", bus.busy, 0);
        end
        check("t3_drops", drop_cnt - r0, 2);
        check("t3_port_sel", bus.port_sel, 0);
        @(posedge aclk); #1;

        // Fill the queue while the active grant is stalled by a silent stream.
        fixed_len = 1; valid_pct = 100; ready_force = 1'b1;
        tb_reset();
        stream_en = 1'b0;
        push_req(0, 1);
        for (int i = 0; i < QD; i++) begin
            push_req((i % 3) + 1, 1);
            @(negedge aclk);
            check("t4_req_ready_fill", bus.req_ready, (i + 1 < QD));
            @(posedge aclk); #1;
        end
        bus.req_valid = 1'b1; bus.req_dest = DB'(2); bus.req_pkts = 8'd1;
        repeat (3) begin
            @(negedge aclk);
            check("t4_held_while_full", bus.req_ready, 0);
        end
        @(posedge aclk); #1 stream_en = 1'b1;
        t = 0;
        @(negedge aclk);
        while (!bus.req_ready && t < 200) begin
            @(negedge aclk);
            t++;
        end
        check("t4_held_accepted", bus.req_ready, 1);
        @(posedge aclk); #1 bus.req_valid = 1'b0;
        drain(500);

        // Back-pressure 1,0,1 during ROUTE with s_tvalid held.
        fixed_len = 3; ready_force = 1'b0;
        tb_reset();
        push_req(2, 1);
        t = 0;
        while (!bus.busy && t < 50) begin
            @(negedge aclk);
            t++;
        end
        check("t5_busy", bus.busy, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk); #1 ready_force = (i != 1);
            c0 = xfer_cnt;
            @(negedge aclk); #1;
            check("t5_s_tready_mirror", bus.s_tready, (i != 1));
            check("t5_mux_tvalid", bus.mux_tvalid, 1);
            check("t5_beat_delta", xfer_cnt - c0, (i != 1));
        end
        @(posedge aclk); #1 ready_force = 1'b1;
        drain(200);

        // Reset during beat 2 of a 4-beat packet, with a second grant queued.
        fixed_len = 4;
        tb_reset();
        stream_en = 1'b0;
        push_req(1, 1);
        push_req(2, 1);
        d0 = done_cnt;
        c0 = xfer_cnt;
        @(posedge aclk); #1 stream_en = 1'b1;
        t = 0;
        while (xfer_cnt == c0 && t < 50) begin
            @(negedge aclk); #1;
            t++;
        end
        check("t6_first_beat", xfer_cnt - c0, 1);
        @(posedge aclk); #1 areset = 1'b1;
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        check("t6_busy", bus.busy, 0);
        check("t6_port_sel", bus.port_sel, 0);
        check("t6_pkt_done", bus.pkt_done, 0);
        check("t6_req_ready", bus.req_ready, 0);
        repeat (6) begin
            @(negedge aclk);
            check("t6_fifo_empty_idle", bus.busy, 0);
        end
        check("t6_no_pkt_done", done_cnt - d0, 0);
        check("t6_beats", xfer_cnt - c0, 1);
        @(posedge aclk); #1;

        // Randomized traffic against the event model.
        fixed_len = 0; valid_pct = 70; rand_ready = 1'b1;
        tb_reset();
        for (int i = 0; i < 40; i++) begin
            int d, p;
            d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(ND, 7)) : int'($urandom_range(0, ND - 1));
            p = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
            push_req(d, p);
            repeat ($urandom_range(0, 3)) begin
                @(posedge aclk); #1;
            end
        end
        drain(6000);

        // Full 8-bit packet count.
        fixed_len = 1; valid_pct = 100; rand_ready = 1'b0; ready_force = 1'b1;
        tb_reset();
        d0 = done_cnt;
        push_req(3, 255);
        drain(2000);
        check("t8_pkt_done_255", done_cnt - d0, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
